// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame stream multiplexer and its
// colour-bar pattern source.
package frame_stream_pkg;

   localparam int RGB_W = 24;

   typedef logic [RGB_W-1:0] tPixel;

   typedef enum logic [1:0] {
      SYNC,
      PASS,
      IDLE,
      PATTERN
   } tMuxState;

   // Standard eight-bar order, left to right, packed {R,G,B}.
   localparam tPixel BAR_COLOUR [0:7] = '{
      24'hFFFFFF,  // white
      24'hFFFF00,  // yellow
      24'h00FFFF,  // cyan
      24'h00FF00,  // green
      24'hFF00FF,  // magenta
      24'hFF0000,  // red
      24'h0000FF,  // blue
      24'h000000   // black
   };

endpackage

// File: rtl/frame_pattern_gen.sv
// Colour-bar test source: walks x/y over one frame and looks up the bar colour
// for the current column. It only moves forward when the consumer takes a pixel.
module frame_pattern_gen
   import frame_stream_pkg::*;
#(
   parameter int FRAME_W = 640,
   parameter int FRAME_H = 480
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  advance,
   input  logic  restart,
   output tPixel pixel,
   output logic  sof,
   output logic  eof
);

   localparam int XW = $clog2(FRAME_W);
   localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
   localparam logic [XW-1:0] BAR_W  = XW'(FRAME_W / 8);

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [2:0]    bar_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (restart) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   assign bar_idx = 3'(x / BAR_W);
   assign pixel   = BAR_COLOUR[bar_idx];
   assign sof     = (x == '0) && (y == '0);
   assign eof     = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/frame_stream_mux.sv
// N-channel pixel-stream selector that only changes source on frame boundaries,
// with a colour-bar fallback source, delivered-frame counter and framing-error flag.
module frame_stream_mux
   import frame_stream_pkg::*;
#(
   parameter  int NUM_CH  = 2,
   parameter  int PIXEL_W = 24,
   parameter  int FRAME_W = 640,
   parameter  int FRAME_H = 480,
   localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      piul1Clock,
   input  logic                      piul1Reset_n,
   input  logic [SEL_W-1:0]          piulSel,
   input  logic                      piul1PatternEn,
   input  logic [NUM_CH-1:0]         piulValid,
   input  logic [NUM_CH*PIXEL_W-1:0] piulData,
   input  logic [NUM_CH-1:0]         piulSof,
   input  logic [NUM_CH-1:0]         piulEof,
   output logic [NUM_CH-1:0]         poulReady,
   output logic [PIXEL_W-1:0]        poulData,
   output logic                      poul1Valid,
   output logic                      poul1Sof,
   output logic                      poul1Eof,
   input  logic                      piul1Ready,
   output logic [SEL_W-1:0]          poulActiveCh,
   output logic                      poul1PatternAct,
   output logic [15:0]               poul16FrameCnt,
   output logic                      poul1FrameErr
);

   tMuxState           state, state_next;
   logic [SEL_W-1:0]   active_ch, active_ch_next, req_ch;
   logic               req_pat;

   logic               out_valid, out_sof, out_eof, frame_err;
   logic [PIXEL_W-1:0] out_data;
   logic [15:0]        frame_cnt;

   logic               act_valid, act_sof, act_eof, act_ready;
   logic [PIXEL_W-1:0] act_data;
   logic               can_load, switching, fwd, pat_load, err_set;
   tPixel              pat_pixel;
   logic               pat_sof, pat_eof;

   assign act_valid = piulValid[active_ch];
   assign act_sof   = piulSof[active_ch];
   assign act_eof   = piulEof[active_ch];
   assign act_data  = piulData[int'(active_ch)*PIXEL_W +: PIXEL_W];
   assign can_load  = !out_valid || piul1Ready;
   assign switching = (req_ch != active_ch);

   // Out-of-range selects are dropped so the last valid request stands.
   always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
      if (!piul1Reset_n) begin
         req_ch  <= '0;
         req_pat <= 1'b0;
      end else begin
         req_pat <= piul1PatternEn;
         if (int'(piulSel) < NUM_CH) req_ch <= piulSel;
      end
   end

   // NOTE: state is registered with non-blocking assignments only; the comb
   // blocks below read the old value for the whole cycle.
   always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
      if (!piul1Reset_n) begin
         state     <= SYNC;
         active_ch <= '0;
      end else begin
         state     <= state_next;
         active_ch <= active_ch_next;
      end
   end

   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      act_ready = 1'b1;
      fwd       = 1'b0;
      pat_load  = 1'b0;
      err_set   = 1'b0;
      case (state)
         SYNC: begin
            act_ready = !act_sof || can_load;
            fwd       = act_valid && act_sof && can_load;
         end
         PASS: begin
            act_ready = can_load;
            fwd       = act_valid && can_load;
            err_set   = fwd && act_sof;
         end
         IDLE: begin
            if (!req_pat && !switching) begin
               act_ready = !act_sof || can_load;
               fwd       = act_valid && act_sof && can_load;
            end
         end
         PATTERN: pat_load = can_load;
         default: ;
      endcase
   end

   always_comb begin
      state_next     = state;
      active_ch_next = active_ch;
      case (state)
         SYNC: if (fwd) state_next = act_eof ? IDLE : PASS;
         PASS: if (fwd && act_eof) state_next = IDLE;
         IDLE: begin
            if (req_pat) begin
               state_next = PATTERN;
            end else if (switching) begin
               active_ch_next = req_ch;
               state_next     = SYNC;
            end else if (fwd) begin
               state_next = act_eof ? IDLE : PASS;
            end else if (act_valid && !act_sof) begin
               state_next = SYNC;
            end
         end
         PATTERN: begin
            if (pat_load && pat_eof && !req_pat) begin
               active_ch_next = req_ch;
               state_next     = SYNC;
            end
         end
         default: state_next = SYNC;
      endcase
   end

   frame_pattern_gen #(
      .FRAME_W (FRAME_W),
      .FRAME_H (FRAME_H)
   ) u_pattern (
      .clk     (piul1Clock),
      .rst_n   (piul1Reset_n),
      .advance (pat_load),
      .restart (state != PATTERN),
      .pixel   (pat_pixel),
      .sof     (pat_sof),
      .eof     (pat_eof)
   );

   always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
      if (!piul1Reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
      end else begin
         frame_err <= err_set;
         if (can_load) begin
            out_valid <= fwd || pat_load;
            if (pat_load) begin
               out_data <= PIXEL_W'(pat_pixel);
               out_sof  <= pat_sof;
               out_eof  <= pat_eof;
            end else if (fwd) begin
               out_data <= act_data;
               out_sof  <= act_sof;
               out_eof  <= act_eof;
            end
         end
         if (out_valid && piul1Ready && out_eof) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Non-active sources are never stalled; everything reads 0 while in reset.
   always_comb begin
      poulReady            = '1;
      poulReady[active_ch] = act_ready;
      if (!piul1Reset_n) poulReady = '0;
   end

   assign poulData        = out_data;
   assign poul1Valid      = out_valid;
   assign poul1Sof        = out_sof;
   assign poul1Eof        = out_eof;
   assign poulActiveCh    = active_ch;
   assign poul1PatternAct = (state == PATTERN);
   assign poul16FrameCnt  = frame_cnt;
   assign poul1FrameErr   = frame_err;

endmodule

// File: tb/tb_frame_stream_mux.sv
// Scoreboard bench for frame_stream_mux: expected beats are queued as stimulus
// is driven and compared in order as the output handshakes.
module tb_frame_stream_mux;

   localparam int NUM_CH  = 3;
   localparam int PIXEL_W = 24;
   localparam int FRAME_W = 16;
   localparam int FRAME_H = 2;

   logic                      clk, rst_n;
   logic [1:0]                sel;
   logic                      pattern_en;
   logic [NUM_CH-1:0]         valid, sof, eof, ready;
   logic [NUM_CH*PIXEL_W-1:0] data;
   logic [PIXEL_W-1:0]        out_data;
   logic                      out_valid, out_sof, out_eof, ds_ready;
   logic [1:0]                active_ch;
   logic                      pattern_act, frame_err;
   logic [15:0]               frame_cnt;

   logic [25:0]               sb_q[$];
   int                        n_checks = 0;
   int                        n_errors = 0;
   int                        err_pulses = 0;
   logic                      toggle_rdy = 1'b0;

   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   frame_stream_mux #(
      .NUM_CH(NUM_CH), .PIXEL_W(PIXEL_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H)
   ) dut (
      .piul1Clock     (clk),
      .piul1Reset_n   (rst_n),
      .piulSel        (sel),
      .piul1PatternEn (pattern_en),
      .piulValid      (valid),
      .piulData       (data),
      .piulSof        (sof),
      .piulEof        (eof),
      .poulReady      (ready),
      .poulData       (out_data),
      .poul1Valid     (out_valid),
      .poul1Sof       (out_sof),
      .poul1Eof       (out_eof),
      .piul1Ready     (ds_ready),
      .poulActiveCh   (active_ch),
      .poul1PatternAct(pattern_act),
      .poul16FrameCnt (frame_cnt),
      .poul1FrameErr  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   initial begin
      ds_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         ds_ready = toggle_rdy ? ~ds_ready : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (ds_ready) begin
            if (sb_q.size() == 0)
               check("unexpected_beat", {6'd0, out_sof, out_eof, out_data}, 32'hFFFF_FFFF);
            else
               check("beat", {6'd0, out_sof, out_eof, out_data}, {6'd0, sb_q.pop_front()});
         end else if (sb_q.size() != 0) begin
            check("stall_hold", {6'd0, out_sof, out_eof, out_data}, {6'd0, sb_q[0]});
         end
      end
      if (rst_n && frame_err) err_pulses++;
   end

   task automatic push(input logic s, input logic e, input logic [23:0] d);
      sb_q.push_back({s, e, d});
   endtask

   task automatic send(input int ch, input logic [23:0] d, input logic s, input logic e);
      int n = 0;
      valid[ch] = 1'b1;
      data[ch*PIXEL_W +: PIXEL_W] = d;
      sof[ch] = s;
      eof[ch] = e;
      @(negedge clk);
      while (!ready[ch] && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) check("ready_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      valid[ch] = 1'b0;
      sof[ch]   = 1'b0;
      eof[ch]   = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int err_base;
      rst_n = 1'b0; sel = '0; pattern_en = 1'b0;
      valid = '0; sof = '0; eof = '0; data = '0;
      #2;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_ready", {29'd0, ready}, 32'd0);
      check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
      check("rst_pattern_act", {31'd0, pattern_act}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single 4x2 frame on ch0 with one-cycle latency.
      for (int i = 0; i < 8; i++) push(i == 0, i == 7, 24'h100000 + 24'(i));
      send(0, 24'h100000, 1'b1, 1'b0);
      check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
      check("t1_latency_sof", {31'd0, out_sof}, 32'd1);
      for (int i = 1; i < 8; i++) send(0, 24'h100000 + 24'(i), 1'b0, i == 7);
      drain();
      check("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);

      // Select ch1 mid-frame: ch0 finishes, ch1 junk dropped until its sof.
      for (int i = 0; i < 8; i++) push(i == 0, i == 7, 24'h200000 + 24'(i));
      for (int j = 0; j < 4; j++) push(j == 0, j == 3, 24'h210000 + 24'(j));
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               if (i == 3) sel = 2'd1;
               send(0, 24'h200000 + 24'(i), i == 0, i == 7);
            end
         end
         begin
            for (int j = 0; j < 12; j++) send(1, 24'h2A0000 + 24'(j), 1'b0, 1'b0);
            for (int j = 0; j < 4; j++) send(1, 24'h210000 + 24'(j), j == 0, j == 3);
         end
      join
      drain();
      check("t2_active_ch", {30'd0, active_ch}, 32'd1);
      check("t2_frame_cnt", {16'd0, frame_cnt}, 32'd3);

      // Downstream ready toggling every cycle.
      toggle_rdy = 1'b1;
      for (int i = 0; i < 8; i++) push(i == 0, i == 7, 24'h300000 + 24'(i));
      for (int i = 0; i < 8; i++) send(1, 24'h300000 + 24'(i), i == 0, i == 7);
      drain();
      toggle_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("t3_frame_cnt", {16'd0, frame_cnt}, 32'd4);
      check("t3_no_err", 32'(err_pulses), 32'd0);

      // One colour-bar frame, then back to ch0.
      for (int y = 0; y < FRAME_H; y++)
         for (int x = 0; x < FRAME_W; x++)
            push(x == 0 && y == 0, x == FRAME_W-1 && y == FRAME_H-1, bars[x / (FRAME_W/8)]);
      pattern_en = 1'b1;
      n = 0;
      while (!pattern_act && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("t4_pattern_act", {31'd0, pattern_act}, 32'd1);
      n = 0;
      while (sb_q.size() > 24 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      pattern_en = 1'b0;
      sel = 2'd0;
      drain();
      check("t4_pattern_off", {31'd0, pattern_act}, 32'd0);
      check("t4_active_ch", {30'd0, active_ch}, 32'd0);
      check("t4_frame_cnt", {16'd0, frame_cnt}, 32'd5);

      // Mid-frame sof on ch0 plus an out-of-range select.
      sel = 2'd3;
      repeat (2) @(posedge clk);
      #1;
      err_base = err_pulses;
      for (int i = 0; i < 8; i++) push(i == 0 || i == 3, i == 7, 24'h500000 + 24'(i));
      for (int i = 0; i < 8; i++) send(0, 24'h500000 + 24'(i), i == 0 || i == 3, i == 7);
      drain();
      check("t5_err_pulse", 32'(err_pulses - err_base), 32'd1);
      check("t5_frame_cnt", {16'd0, frame_cnt}, 32'd6);
      push(1'b1, 1'b1, 24'h5F0000);
      send(0, 24'h5F0000, 1'b1, 1'b1);
      drain();
      check("t5_sel_ignored", {30'd0, active_ch}, 32'd0);
      check("t5_frame_cnt2", {16'd0, frame_cnt}, 32'd7);

      // Reset mid-frame, then counter wrap.
      sel = 2'd0;
      for (int i = 0; i < 3; i++) push(i == 0, 1'b0, 24'h600000 + 24'(i));
      for (int i = 0; i < 3; i++) send(0, 24'h600000 + 24'(i), i == 0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      sb_q.delete();
      check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      check("t6_rst_data", {8'd0, out_data}, 32'd0);
      check("t6_rst_sof", {31'd0, out_sof}, 32'd0);
      check("t6_rst_ready", {29'd0, ready}, 32'd0);
      check("t6_rst_cnt", {16'd0, frame_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_active_ch", {30'd0, active_ch}, 32'd0);
      check("t6_pattern_act", {31'd0, pattern_act}, 32'd0);
      send(0, 24'h6B0000, 1'b0, 1'b0);
      for (int i = 0; i < 65535; i++) begin
         push(1'b1, 1'b1, 24'(i));
         send(0, 24'(i), 1'b1, 1'b1);
      end
      drain();
      check("t6_cnt_max", {16'd0, frame_cnt}, 32'h0000_FFFF);
      push(1'b1, 1'b1, 24'hABCDEF);
      send(0, 24'hABCDEF, 1'b1, 1'b1);
      drain();
      check("t6_cnt_wrap", {16'd0, frame_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
